word_builder: RTL and testbench

- Front end for the DTW word matcher.
- Collects recognized characters from the glove classifier into a 15-char packed word, one at a time.
- On commit, fetches the 20-entry candidate group for the word's first letter from the dictionary ROM.
- Drives the DTW start/word/candidate inputs, waits for its finish pulse, and presents the matched word on a valid/ready result port.

---
 rtl/word_builder.sv | 205 ++++++++++++++++++++
 tb/tb_word_builder.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_builder.sv
// word_builder: packs classified glove characters into a word, fetches the
// dictionary group for its first letter and hands both to the DTW matcher.
// Optional DTW watchdog: define WB_TIMEOUT_EN.
module word_builder (
  input  logic         i_WB_clk,
  input  logic         i_WB_rst_n,
  input  logic         i_WB_char_valid,
  input  logic [7:0]   i_WB_char,
  output logic         o_WB_char_ready,
  input  logic         i_WB_commit,
  output logic [9:0]   o_WB_dict_addr,
  input  logic [119:0] i_WB_dict_data,
  output logic         o_WB_DTW_start,
  output logic [119:0] o_WB_DTW_word,
  output logic [119:0] o_WB_DTW_candidate_word [0:19],
  input  logic         i_WB_DTW_finish,
  input  logic [119:0] i_WB_DTW_word,
  output logic         o_WB_result_valid,
  output logic [119:0] o_WB_result,
  input  logic         i_WB_result_ready,
  output logic         o_WB_overflow,
`ifdef WB_TIMEOUT_EN
  output logic         o_WB_timeout,
`endif
  output logic [2:0]   o_WB_state
);

  localparam int unsigned CHAR_NUM = 15;
  localparam int unsigned CHAR_W   = 8;
  localparam int unsigned WORD_W   = CHAR_NUM * CHAR_W;
  localparam int unsigned CAND_NUM = 20;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned K_W      = 5;
  localparam int unsigned LEN_W    = 4;
  localparam logic [7:0]  LETTER_A = 8'h61;
  localparam logic [7:0]  LETTER_Z = 8'h7a;
  localparam logic [7:0]  BKSP     = 8'h08;
`ifdef WB_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYCLES = 1023;
  localparam int unsigned CNT_W          = 10;
`endif

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_FETCH   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_OUT     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   cand_q [0:CAND_NUM-1];
  logic [WORD_W-1:0]   cand_d [0:CAND_NUM-1];
  logic [WORD_W-1:0]   result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                start_q, start_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic [7:0]          grp_c;
  logic                is_letter_c;
`ifdef WB_TIMEOUT_EN
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
`endif

  assign is_letter_c = (i_WB_char >= LETTER_A) && (i_WB_char <= LETTER_Z);

  // Next-state, buffer editing, fetch sequencing and result capture
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    len_d    = len_q;
    k_d      = k_q;
    addr_d   = addr_q;
    cand_d   = cand_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    grp_c    = '0;
`ifdef WB_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_COLLECT: begin
        if (i_WB_char_valid) begin
          if (is_letter_c) begin
            if (len_q < LEN_W'(CHAR_NUM)) begin
              word_d[{len_q, 3'b000} +: CHAR_W] = i_WB_char;
              len_d = len_q + LEN_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (i_WB_char == BKSP && len_q != '0) begin
            word_d[{len_q - LEN_W'(1), 3'b000} +: CHAR_W] = '0;
            len_d = len_q - LEN_W'(1);
          end
        end
        // Commit sees the buffer after this cycle's character edit
        if (i_WB_commit && len_d != '0) begin
          grp_c   = word_d[7:0] - LETTER_A;
          addr_d  = ADDR_W'(grp_c) * ADDR_W'(CAND_NUM);
          k_d     = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // ROM data lags its address by one cycle
        if (k_q != '0) cand_d[k_q - K_W'(1)] = i_WB_dict_data;
        if (k_q < K_W'(CAND_NUM - 1)) addr_d = addr_q + ADDR_W'(1);
        if (k_q == K_W'(CAND_NUM)) begin
          k_d     = '0;
          state_d = S_START;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_WB_DTW_finish) begin
          result_d = i_WB_DTW_word;
          state_d  = S_OUT;
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_d  = word_q;
          timeout_d = 1'b1;
          state_d   = S_OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_OUT: begin
        if (i_WB_result_ready) begin
          word_d  = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
`ifdef WB_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
    start_d = (state_d == S_START);
    valid_d = (state_d == S_OUT);
    ready_d = (state_d == S_COLLECT);
  end

  // State register; i_WB_rst_n is an active-high synchronous reset
  always_ff @(posedge i_WB_clk) begin
    if (i_WB_rst_n) begin
      state_q  <= S_COLLECT;
      word_q   <= '0;
      len_q    <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      cand_q   <= '{default: '0};
      result_q <= '0;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
`ifdef WB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      len_q    <= len_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      cand_q   <= cand_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
`ifdef WB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_WB_char_ready         = ready_q;
  assign o_WB_dict_addr          = addr_q;
  assign o_WB_DTW_start          = start_q;
  assign o_WB_DTW_word           = word_q;
  assign o_WB_DTW_candidate_word = cand_q;
  assign o_WB_result_valid       = valid_q;
  assign o_WB_result             = result_q;
  assign o_WB_overflow           = ovf_q;
  assign o_WB_state              = state_q;
`ifdef WB_TIMEOUT_EN
  assign o_WB_timeout            = timeout_q;
`endif

endmodule

// File: tb/tb_word_builder.sv
// Scoreboard bench for word_builder: random words against a character-queue
// model, with a ROM model and a scripted DTW responder.
module tb_word_builder;

  localparam int unsigned W = 120;

  logic         clk = 1'b0;
  logic         rst, char_valid, commit, dtw_finish, res_ready;
  logic [7:0]   ch;
  logic [9:0]   dict_addr;
  logic [W-1:0] dict_data, dtw_word_o, dtw_word_i, result;
  logic [W-1:0] cand [0:19];
  logic         char_ready, dtw_start, res_valid, ovf;
  logic [2:0]   state;
`ifdef WB_TIMEOUT_EN
  logic         timeout;
`endif

  typedef struct { logic [W-1:0] word; int grp; int cyc; } start_t;
  typedef struct { logic [W-1:0] word; logic to; } res_t;

  start_t       exp_start[$];
  res_t         exp_res[$];
  logic [9:0]   addr_log[$];
  logic [W-1:0] rom [0:1023];
  logic [7:0]   mchars[$];
  bit           movf;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_err = 0;

  word_builder dut (
    .i_WB_clk                (clk),
    .i_WB_rst_n              (rst),
    .i_WB_char_valid         (char_valid),
    .i_WB_char               (ch),
    .o_WB_char_ready         (char_ready),
    .i_WB_commit             (commit),
    .o_WB_dict_addr          (dict_addr),
    .i_WB_dict_data          (dict_data),
    .o_WB_DTW_start          (dtw_start),
    .o_WB_DTW_word           (dtw_word_o),
    .o_WB_DTW_candidate_word (cand),
    .i_WB_DTW_finish         (dtw_finish),
    .i_WB_DTW_word           (dtw_word_i),
    .o_WB_result_valid       (res_valid),
    .o_WB_result             (result),
    .i_WB_result_ready       (res_ready),
    .o_WB_overflow           (ovf),
`ifdef WB_TIMEOUT_EN
    .o_WB_timeout            (timeout),
`endif
    .o_WB_state              (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) dict_data <= rom[dict_addr];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand120();
    logic [W-1:0] r;
    r[31:0]   = $urandom();
    r[63:32]  = $urandom();
    r[95:64]  = $urandom();
    r[119:96] = 24'($urandom());
    return r;
  endfunction

  function automatic logic [7:0] rand_letter();
    return 8'($urandom_range(97, 122));
  endfunction

  // Reference model: the word is just a queue of typed letters
  function automatic void model_char(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7a) begin
      if (mchars.size() < 15) mchars.push_back(c);
      else movf = 1'b1;
    end else if (c == 8'h08 && mchars.size() != 0) begin
      void'(mchars.pop_back());
    end
  endfunction

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < mchars.size(); i++) w[i*8 +: 8] = mchars[i];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    check("wait_state", W'(state), W'(s));
  endtask

  task automatic send_char(input logic [7:0] c);
    char_valid = 1'b1;
    ch = c;
    model_char(c);
    tick();
    char_valid = 1'b0;
  endtask

  task automatic commit_word(input bit with_char, input logic [7:0] c);
    if (with_char) begin
      char_valid = 1'b1;
      ch = c;
      model_char(c);
    end
    commit = 1'b1;
    if (mchars.size() != 0) begin
      start_t e;
      e.word = model_word();
      e.grp  = int'(mchars[0]) - 97;
      e.cyc  = cyc;
      exp_start.push_back(e);
    end
    tick();
    commit = 1'b0;
    char_valid = 1'b0;
  endtask

  task automatic finish_word(input int fin_delay, input int rdy_delay, input bit junk,
                             input logic [W-1:0] ret);
    logic [W-1:0] wexp = model_word();
    res_t r;
    wait_state(3'd3, 40);
    for (int i = 0; i < fin_delay; i++) begin
      if (junk) begin
        char_valid = 1'b1;
        ch = rand_letter();
        commit = 1'b1;
      end
      tick();
    end
    char_valid = 1'b0;
    commit = 1'b0;
    check("wait_word_hold", dtw_word_o, wexp);
    check("wait_state_hold", W'(state), W'(3));
    dtw_finish = 1'b1;
    dtw_word_i = ret;
    r.word = ret;
    r.to = 1'b0;
    exp_res.push_back(r);
    tick();
    dtw_finish = 1'b0;
    check("out_state", W'(state), W'(4));
    check("valid_up", W'(res_valid), W'(1));
    for (int i = 0; i < rdy_delay; i++) begin
      if (i == 0) begin
        dtw_finish = 1'b1;
        dtw_word_i = rand120();
      end
      tick();
      dtw_finish = 1'b0;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    mchars.delete();
    movf = 1'b0;
    check("back_to_collect", W'(state), W'(0));
    check("ovf_cleared", W'(ovf), W'(0));
    check("valid_drop", W'(res_valid), W'(0));
  endtask

  // Monitor: start pulses, result handshakes and result hold
  logic         prev_valid = 1'b0;
  logic         prev_acc = 1'b0;
  logic [W-1:0] prev_result = '0;
  always @(negedge clk) begin
    start_t e;
    res_t   r;
    int     bad;
    if (!rst) begin
      if (state == 3'd1) addr_log.push_back(dict_addr);
      if (dtw_start) begin
        check("start_expected", W'(exp_start.size() != 0), W'(1));
        if (exp_start.size() != 0) begin
          e = exp_start.pop_front();
          check("dtw_word", dtw_word_o, e.word);
          check("start_latency", W'(cyc - e.cyc), W'(22));
          bad = 0;
          for (int k = 0; k < 20; k++) if (cand[k] !== rom[e.grp*20 + k]) bad++;
          check("cand_bank", W'(bad), W'(0));
          bad = 0;
          if (addr_log.size() < 20) bad = 99;
          else for (int k = 0; k < 20; k++) if (addr_log[k] !== 10'(e.grp*20 + k)) bad++;
          check("dict_addr_seq", W'(bad), W'(0));
        end
        addr_log.delete();
      end
      if (res_valid && res_ready) begin
        check("result_expected", W'(exp_res.size() != 0), W'(1));
        if (exp_res.size() != 0) begin
          r = exp_res.pop_front();
          check("result", result, r.word);
`ifdef WB_TIMEOUT_EN
          check("timeout_flag", W'(timeout), W'(r.to));
`endif
        end
      end
      if (prev_valid && !prev_acc) begin
        check("valid_hold", W'(res_valid), W'(1));
        check("result_hold", result, prev_result);
      end
      prev_valid  = res_valid;
      prev_acc    = res_valid && res_ready;
      prev_result = result;
    end else begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
      addr_log.delete();
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, bad;
    logic [7:0] c;
    rst = 1'b1; char_valid = 1'b0; ch = '0; commit = 1'b0;
    dtw_finish = 1'b0; dtw_word_i = '0; res_ready = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = rand120();
    repeat (3) tick();

    // Reset values
    check("rst_state", W'(state), W'(0));
    check("rst_ready", W'(char_ready), W'(1));
    check("rst_valid", W'(res_valid), W'(0));
    check("rst_start", W'(dtw_start), W'(0));
    check("rst_ovf", W'(ovf), W'(0));
    check("rst_addr", W'(dict_addr), W'(0));
    check("rst_word", dtw_word_o, W'(0));
    check("rst_result", result, W'(0));
    rst = 1'b0;
    tick();
    check("ready_after_rst", W'(char_ready), W'(1));

    // "cat": group 2, addresses 40..59
    send_char(8'h63); send_char(8'h61); send_char(8'h74);
    commit_word(1'b0, 8'h00);
    wait_state(3'd3, 40);
    check("cat_word", dtw_word_o, W'(120'h746163));
    finish_word(3, 2, 1'b0, W'(120'h746163));

    // Overflow then two backspaces
    for (int i = 0; i < 16; i++) send_char(rand_letter());
    check("ovf_set", W'(ovf), W'(1));
    send_char(8'h08); send_char(8'h08);
    check("ovf_sticky", W'(ovf), W'(1));
    commit_word(1'b0, 8'h00);
    finish_word(5, 1, 1'b0, rand120());

    // Empty commit, no-op edits, then char+commit in one cycle
    commit_word(1'b0, 8'h00);
    repeat (3) tick();
    check("empty_commit_state", W'(state), W'(0));
    check("empty_commit_reads", W'(addr_log.size()), W'(0));
    send_char(8'h08);
    send_char(8'h35);
    check("noop_state", W'(state), W'(0));
    commit_word(1'b1, 8'h62);
    finish_word(4, 50, 1'b1, rand120());

    // Random words
    repeat (6) begin
      n = $urandom_range(1, 18);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        c = (r == 0) ? 8'h08 : (r == 1) ? 8'($urandom_range(32, 96)) : rand_letter();
        send_char(c);
      end
      if (mchars.size() == 0) send_char(rand_letter());
      check("ovf_model", W'(ovf), W'(movf));
      commit_word(1'($urandom_range(0, 1)), rand_letter());
      finish_word($urandom_range(0, 10), $urandom_range(0, 5), 1'($urandom_range(0, 1)), rand120());
    end

    // Reset during fetch at k = 7
    send_char(rand_letter()); send_char(rand_letter());
    commit_word(1'b0, 8'h00);
    repeat (7) tick();
    check("mid_fetch_state", W'(state), W'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_start.delete();
    mchars.delete();
    movf = 1'b0;
    check("rst_fetch_state", W'(state), W'(0));
    check("rst_fetch_start", W'(dtw_start), W'(0));
    bad = 0;
    for (int k = 0; k < 20; k++) if (cand[k] !== '0) bad++;
    check("rst_fetch_bank", W'(bad), W'(0));
    repeat (30) tick();
    check("rst_fetch_idle", W'(state), W'(0));
    send_char(8'h7a); send_char(8'h6f);
    commit_word(1'b0, 8'h00);
    finish_word(2, 3, 1'b0, rand120());

`ifdef WB_TIMEOUT_EN
    // No finish: timeout returns the input word
    begin
      res_t tr;
      send_char(8'h64); send_char(8'h6f); send_char(8'h67);
      commit_word(1'b0, 8'h00);
      wait_state(3'd3, 40);
      repeat (1022) tick();
      check("pre_timeout_state", W'(state), W'(3));
      tr.word = model_word();
      tr.to = 1'b1;
      exp_res.push_back(tr);
      tick();
      check("timeout_state", W'(state), W'(4));
      check("timeout_set", W'(timeout), W'(1));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      mchars.delete();
      check("timeout_clear", W'(timeout), W'(0));
      // Finish on the last allowed cycle wins
      send_char(8'h65);
      commit_word(1'b0, 8'h00);
      wait_state(3'd3, 40);
      repeat (1022) tick();
      dtw_finish = 1'b1;
      dtw_word_i = rand120();
      tr.word = dtw_word_i;
      tr.to = 1'b0;
      exp_res.push_back(tr);
      tick();
      dtw_finish = 1'b0;
      check("finish_wins", W'(timeout), W'(0));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      mchars.delete();
    end
`endif

    repeat (5) tick();
    check("start_queue_drained", W'(exp_start.size()), W'(0));
    check("result_queue_drained", W'(exp_res.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
